blink_pattern_gen: RTL and testbench

Parametrised LED pattern generator and successor to the single-rate 8-bit blink counter. A programmable prescaler produces a slow tick with run-time speed select. Each tick advances one of four display patterns: binary count, Gray count, bounce (scanner) or one-hot rotate. The block drives the user output pins directly and exports tick/wrap pulses for other logic.

---
 rtl/blink_pkg.sv | 17 +
 rtl/blink_prescaler.sv | 42 ++++
 rtl/blink_pattern_gen.sv | 139 +++++++++++++
 tb/tb_blink_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants for the blink pattern generator: display modes and
// direction encodings used by the top and the testbench.
package blink_pkg;

   typedef enum logic [1:0] {
      MODE_BIN    = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_ROTATE = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/blink_prescaler.sv
// Programmable prescaler: counts clocks and raises step when the count
// reaches the speed-scaled terminal value.
module blink_prescaler
   import blink_pkg::*;
#(
   parameter int DIV_WIDTH    = 25,
   parameter int DIV_TERMINAL = 24999999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] speed,
   input  logic       clr,
   output logic       step
);

   localparam logic [DIV_WIDTH-1:0] TERM_BASE = DIV_WIDTH'(DIV_TERMINAL);

   logic [DIV_WIDTH-1:0] r_divCnt;
   logic [DIV_WIDTH-1:0] w_term;
   logic                 w_reached;

   // Greater-or-equal so that a faster speed chosen mid-count fires at the next edge.
   assign w_term    = TERM_BASE >> speed;
   assign w_reached = (r_divCnt >= w_term);
   assign step      = en && w_reached && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divCnt <= '0;
      end else if (clr) begin
         r_divCnt <= '0;
      end else if (en) begin
         if (w_reached) begin
            r_divCnt <= '0;
         end else begin
            r_divCnt <= r_divCnt + DIV_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/blink_pattern_gen.sv
// LED pattern generator: prescaled tick advances a binary/Gray counter or a
// bouncing/rotating one-hot, decoded onto the display pattern by mode.
module blink_pattern_gen
   import blink_pkg::*;
#(
   parameter int OUT_WIDTH    = 8,
   parameter int DIV_WIDTH    = 25,
   parameter int DIV_TERMINAL = 24999999
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic                 dir,
   input  logic [1:0]           speed,
   input  logic                 load,
   input  logic [OUT_WIDTH-1:0] load_val,
   output logic [OUT_WIDTH-1:0] pattern,
   output logic                 tick,
   output logic                 wrap
);

   localparam logic [OUT_WIDTH-1:0] ALL_ONES    = '1;
   localparam logic [OUT_WIDTH-1:0] ONEHOT_LSB  = OUT_WIDTH'(1);
   localparam logic [OUT_WIDTH-1:0] ONEHOT_BIT1 = OUT_WIDTH'(2);
   localparam logic [OUT_WIDTH-1:0] ONEHOT_MSB1 = ONEHOT_LSB << (OUT_WIDTH - 2);

   logic [OUT_WIDTH-1:0] r_cnt;
   logic [OUT_WIDTH-1:0] r_onehot;
   dir_e                 r_bdir;
   logic                 r_tick;
   logic                 r_wrap;

   logic                 w_step;
   logic [OUT_WIDTH-1:0] w_cntNext;
   logic [OUT_WIDTH-1:0] w_onehotNext;
   dir_e                 w_bdirNext;
   logic                 w_wrapNext;

   blink_prescaler #(
      .DIV_WIDTH    (DIV_WIDTH),
      .DIV_TERMINAL (DIV_TERMINAL)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .speed (speed),
      .clr   (load),
      .step  (w_step)
   );

   // Successor state for one step; only the state owned by the active mode moves.
   always_comb begin
      w_cntNext    = r_cnt;
      w_onehotNext = r_onehot;
      w_bdirNext   = r_bdir;
      w_wrapNext   = 1'b0;
      case (mode_e'(mode))
         MODE_BIN, MODE_GRAY: begin
            if (dir == DIR_UP) begin
               w_cntNext  = r_cnt + OUT_WIDTH'(1);
               w_wrapNext = (r_cnt == ALL_ONES);
            end else begin
               w_cntNext  = r_cnt - OUT_WIDTH'(1);
               w_wrapNext = (r_cnt == '0);
            end
         end
         MODE_BOUNCE: begin
            if (r_bdir == DIR_UP) begin
               if (r_onehot[OUT_WIDTH-1]) begin
                  w_onehotNext = ONEHOT_MSB1;
                  w_bdirNext   = DIR_DOWN;
                  w_wrapNext   = 1'b1;
               end else begin
                  w_onehotNext = r_onehot << 1;
               end
            end else begin
               if (r_onehot[0]) begin
                  w_onehotNext = ONEHOT_BIT1;
                  w_bdirNext   = DIR_UP;
                  w_wrapNext   = 1'b1;
               end else begin
                  w_onehotNext = r_onehot >> 1;
               end
            end
         end
         MODE_ROTATE: begin
            if (dir == DIR_UP) begin
               w_onehotNext = {r_onehot[OUT_WIDTH-2:0], r_onehot[OUT_WIDTH-1]};
               w_wrapNext   = r_onehot[OUT_WIDTH-1];
            end else begin
               w_onehotNext = {r_onehot[0], r_onehot[OUT_WIDTH-1:1]};
               w_wrapNext   = r_onehot[0];
            end
         end
         default: begin
         end
      endcase
   end

   // Load outranks a coincident step and silences that edge's tick/wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_onehot <= ONEHOT_LSB;
         r_bdir   <= DIR_UP;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (load) begin
         r_cnt    <= load_val;
         r_onehot <= ONEHOT_LSB;
         r_bdir   <= DIR_UP;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (w_step) begin
         r_cnt    <= w_cntNext;
         r_onehot <= w_onehotNext;
         r_bdir   <= w_bdirNext;
         r_tick   <= 1'b1;
         r_wrap   <= w_wrapNext;
      end else begin
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end
   end

   always_comb begin
      pattern = r_onehot;
      case (mode_e'(mode))
         MODE_BIN:  pattern = r_cnt;
         MODE_GRAY: pattern = r_cnt ^ (r_cnt >> 1);
         default:   pattern = r_onehot;
      endcase
   end

   assign tick = r_tick;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_blink_pattern_gen.sv
// Self-checking bench for blink_pattern_gen: directed scenarios plus a random
// phase, all compared against a position/integer reference model.
module tb_blink_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       dir = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic [7:0] pattern;
   logic       tick;
   logic       wrap;

   int testCount = 0;
   int failCount = 0;

   // Reference model: counter as integer, one-hot as a bit position.
   int mDiv = 0;
   int mCnt = 0;
   int mPos = 0;
   bit mBounceUp = 1'b1;
   bit mTick = 1'b0;
   bit mWrap = 1'b0;

   blink_pattern_gen #(
      .OUT_WIDTH    (8),
      .DIV_WIDTH    (8),
      .DIV_TERMINAL (15)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .speed    (speed),
      .load     (load),
      .load_val (load_val),
      .pattern  (pattern),
      .tick     (tick),
      .wrap     (wrap)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      int term;
      if (rst) begin
         mDiv = 0; mCnt = 0; mPos = 0; mBounceUp = 1'b1; mTick = 1'b0; mWrap = 1'b0;
      end else begin
         term = 15 >> speed;
         mTick = 1'b0;
         mWrap = 1'b0;
         if (load) begin
            mCnt = int'(load_val); mPos = 0; mBounceUp = 1'b1; mDiv = 0;
         end else if (en && mDiv < term) begin
            mDiv = mDiv + 1;
         end else if (en) begin
            mDiv = 0;
            mTick = 1'b1;
            if (mode < 2) begin
               if (!dir) begin
                  mWrap = (mCnt == 255);
                  mCnt = (mCnt + 1) % 256;
               end else begin
                  mWrap = (mCnt == 0);
                  mCnt = (mCnt + 255) % 256;
               end
            end else if (mode == 2) begin
               if (mBounceUp && mPos == 7) begin
                  mBounceUp = 1'b0; mPos = 6; mWrap = 1'b1;
               end else if (!mBounceUp && mPos == 0) begin
                  mBounceUp = 1'b1; mPos = 1; mWrap = 1'b1;
               end else begin
                  mPos = mBounceUp ? mPos + 1 : mPos - 1;
               end
            end else begin
               if (!dir) begin
                  mWrap = (mPos == 7);
                  mPos = (mPos + 1) % 8;
               end else begin
                  mWrap = (mPos == 0);
                  mPos = (mPos + 7) % 8;
               end
            end
         end
      end
   end

   function automatic logic [7:0] expPattern();
      case (mode)
         2'd0:    return 8'(mCnt);
         2'd1:    return 8'(mCnt ^ (mCnt >> 1));
         default: return 8'(1 << mPos);
      endcase
   endfunction

   task automatic checkOutput(input string tag);
      testCount++;
      assert (pattern === expPattern()) else begin
         failCount++;
         $error("FAIL %s pattern: observed %h expected %h", tag, pattern, expPattern());
      end
      testCount++;
      assert (tick === mTick) else begin
         failCount++;
         $error("FAIL %s tick: observed %b expected %b", tag, tick, mTick);
      end
      testCount++;
      assert (wrap === mWrap) else begin
         failCount++;
         $error("FAIL %s wrap: observed %b expected %b", tag, wrap, mWrap);
      end
   endtask

   task automatic checkConst(input string tag, input logic [7:0] p, input logic t, input logic w);
      testCount++;
      assert (pattern === p && tick === t && wrap === w) else begin
         failCount++;
         $error("FAIL %s: observed pattern=%h tick=%b wrap=%b expected pattern=%h tick=%b wrap=%b",
                tag, pattern, tick, wrap, p, t, w);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] m, input logic d,
                                input logic [1:0] s, input logic l, input logic [7:0] lv);
      en = e; mode = m; dir = d; speed = s; load = l; load_val = lv;
   endtask

   task automatic runCycles(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput(tag);
      end
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic asyncReset(input string tag);
      #3 rst = 1'b1;
      #1 checkOutput(tag);
      checkConst({tag, "-pulses"}, pattern, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic       rEn;
      logic [1:0] rMode;
      logic       rDir;
      logic [1:0] rSpeed;
      logic       rLoad;
      logic [7:0] rVal;

      rst = 1'b1;
      applyStimulus(0, 2'd0, 0, 2'd0, 0, 8'h00);
      @(negedge clk);
      checkConst("reset", 8'h00, 1'b0, 1'b0);
      checkOutput("reset-model");
      rst = 1'b0;

      // Binary up at period 4 through a full 256-tick wrap.
      applyStimulus(1, 2'd0, 0, 2'd2, 0, 8'h00);
      runCycles(1020, "bin-up");
      checkConst("bin-255", 8'hFF, 1'b1, 1'b0);
      runCycles(4, "bin-up");
      checkConst("bin-wrap", 8'h00, 1'b1, 1'b1);
      runCycles(1, "bin-up");
      checkConst("bin-wrap-1cyc", 8'h00, 1'b0, 1'b0);

      // Binary down from reset, then Gray decode of a loaded 3.
      pulseReset();
      applyStimulus(1, 2'd0, 1, 2'd2, 0, 8'h00);
      runCycles(4, "bin-down");
      checkConst("bin-down-wrap", 8'hFF, 1'b1, 1'b1);
      applyStimulus(0, 2'd0, 1, 2'd2, 1, 8'h03);
      runCycles(1, "load3");
      load = 1'b0;
      mode = 2'd1;
      #1 checkConst("gray-3", 8'h02, 1'b0, 1'b0);
      checkOutput("gray-3-model");

      // Bounce at period 2.
      pulseReset();
      applyStimulus(1, 2'd2, 0, 2'd3, 0, 8'h00);
      runCycles(14, "bounce");
      checkConst("bounce-msb", 8'h80, 1'b1, 1'b0);
      runCycles(2, "bounce");
      checkConst("bounce-top", 8'h40, 1'b1, 1'b1);
      runCycles(12, "bounce");
      checkConst("bounce-lsb", 8'h01, 1'b1, 1'b0);
      runCycles(2, "bounce");
      checkConst("bounce-bottom", 8'h02, 1'b1, 1'b1);

      // Rotate right.
      pulseReset();
      applyStimulus(1, 2'd3, 1, 2'd3, 0, 8'h00);
      runCycles(2, "rot-right");
      checkConst("rot-wrap", 8'h80, 1'b1, 1'b1);
      runCycles(2, "rot-right");
      checkConst("rot-next", 8'h40, 1'b1, 1'b0);

      // Speed change mid-count.
      pulseReset();
      applyStimulus(1, 2'd0, 0, 2'd0, 0, 8'h00);
      runCycles(15, "speed0");
      checkConst("speed0-pre", 8'h00, 1'b0, 1'b0);
      runCycles(1, "speed0");
      checkConst("speed0-tick", 8'h01, 1'b1, 1'b0);
      runCycles(10, "speed0");
      checkConst("speed0-div10", 8'h01, 1'b0, 1'b0);
      speed = 2'd3;
      runCycles(1, "speed3");
      checkConst("speed3-first", 8'h02, 1'b1, 1'b0);
      runCycles(1, "speed3");
      checkConst("speed3-gap", 8'h02, 1'b0, 1'b0);
      runCycles(1, "speed3");
      checkConst("speed3-second", 8'h03, 1'b1, 1'b0);

      // Load while disabled, hold, load against a step, async reset.
      applyStimulus(0, 2'd0, 0, 2'd0, 1, 8'hA5);
      runCycles(1, "load-a5");
      checkConst("load-a5", 8'hA5, 1'b0, 1'b0);
      load = 1'b0;
      runCycles(50, "hold");
      checkConst("hold-a5", 8'hA5, 1'b0, 1'b0);
      applyStimulus(1, 2'd0, 0, 2'd3, 0, 8'h00);
      runCycles(1, "pre-step");
      applyStimulus(1, 2'd0, 0, 2'd3, 1, 8'h3C);
      runCycles(1, "load-vs-step");
      checkConst("load-wins", 8'h3C, 1'b0, 1'b0);
      load = 1'b0;
      runCycles(3, "post-load");
      #3 rst = 1'b1;
      #1 checkConst("async-rst", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Random phase.
      rMode = 2'd0; rDir = 1'b0; rSpeed = 2'd3;
      for (int i = 0; i < 1500; i++) begin
         rEn = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) rMode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) rDir = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) rSpeed = 2'($urandom_range(0, 3));
         rLoad = ($urandom_range(0, 31) == 0);
         rVal = 8'($urandom);
         applyStimulus(rEn, rMode, rDir, rSpeed, rLoad, rVal);
         if ($urandom_range(0, 299) == 0) begin
            asyncReset("rand-rst");
         end else begin
            runCycles(1, "random");
         end
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
